// File: rtl/voter_if.sv
// 4-input voting machine: registered one-hot verdict, yes count and saturating pass count.
// Optional chair tiebreak on I[0] is enabled by defining VOTER_IF_TIEBREAK_EN.
module voter_if #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       I,
  output logic [3:1]       O,
  output logic [2:0]       yes_cnt,
  output logic [CNT_W-1:0] pass_cnt
);

  localparam logic [3:1] V_PASS = 3'b100;
  localparam logic [3:1] V_TIE  = 3'b010;
  localparam logic [3:1] V_FAIL = 3'b001;

  logic [2:0]       w_n;
  logic [3:1]       w_verdict;
  logic [3:1]       r_o;
  logic [2:0]       r_yes_cnt;
  logic [CNT_W-1:0] r_pass_cnt;

  assign w_n = {2'b00, I[0]} + {2'b00, I[1]} + {2'b00, I[2]} + {2'b00, I[3]};

  // NOTE: default assignment first so every path drives w_verdict and no latch is inferred.
  always_comb begin
    w_verdict = V_FAIL;
    if (w_n >= 3'd3) begin
      w_verdict = V_PASS;
    end else if (w_n == 3'd2) begin
`ifdef VOTER_IF_TIEBREAK_EN
      w_verdict = I[0] ? V_PASS : V_FAIL;
`else
      w_verdict = V_TIE;
`endif
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_o        <= '0;
      r_yes_cnt  <= '0;
      r_pass_cnt <= '0;
    end else if (en) begin
      r_o       <= w_verdict;
      r_yes_cnt <= w_n;
      if (w_verdict == V_PASS && r_pass_cnt != {CNT_W{1'b1}}) begin
        r_pass_cnt <= r_pass_cnt + 1'b1;
      end
    end
  end

  assign O        = r_o;
  assign yes_cnt  = r_yes_cnt;
  assign pass_cnt = r_pass_cnt;

endmodule

// File: tb/tb_voter_if.sv
// Directed bench for voter_if: reset, full input sweep, hold, saturation (CNT_W=2),
// tiebreak behaviour (follows VOTER_IF_TIEBREAK_EN) and mid-operation reset.
module tb_voter_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] I;
  logic [3:1] O;
  logic [2:0] yes_cnt;
  logic [7:0] pass_cnt;

  logic       en_s;
  logic [3:0] i_s;
  logic [3:1] o_s;
  logic [2:0] yes_s;
  logic [1:0] pass_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  voter_if #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .I(I),
    .O(O), .yes_cnt(yes_cnt), .pass_cnt(pass_cnt)
  );

  voter_if #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en_s), .I(i_s),
    .O(o_s), .yes_cnt(yes_s), .pass_cnt(pass_s)
  );

  // Hand-computed expectations per input code 0..15.
  logic [2:0] exp_yes [16] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3,
                               3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3, 3'd3, 3'd4};
`ifdef VOTER_IF_TIEBREAK_EN
  logic [2:0] exp_o [16] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100,
                             3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b100, 3'b100};
  localparam int SWEEP_PASS = 8;
`else
  logic [2:0] exp_o [16] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b010, 3'b010, 3'b100,
                             3'b001, 3'b010, 3'b010, 3'b100, 3'b010, 3'b100, 3'b100, 3'b100};
  localparam int SWEEP_PASS = 5;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [2:0] e_o,
                            input logic [2:0] e_yes, input logic [7:0] e_pass);
    check({tag, ".O"}, 32'(O), 32'(e_o));
    check({tag, ".yes_cnt"}, 32'(yes_cnt), 32'(e_yes));
    check({tag, ".pass_cnt"}, 32'(pass_cnt), 32'(e_pass));
  endtask

  initial begin
    logic [7:0] pass_exp;
    rst_n = 1'b0; en = 1'b1; I = 4'b1111;
    en_s = 1'b1; i_s = 4'b1111;

    // Reset dominates en with all-yes input.
    for (int k = 0; k < 3; k++) begin
      step();
      check_main($sformatf("reset%0d", k), 3'b000, 3'd0, 8'd0);
      check($sformatf("reset%0d.sat_pass", k), 32'(pass_s), 32'd0);
    end

    // Sweep all codes, one per cycle.
    rst_n = 1'b1; en_s = 1'b0;
    pass_exp = 8'd0;
    for (int c = 0; c < 16; c++) begin
      I = 4'(c);
      step();
      if (exp_o[c] == 3'b100) pass_exp++;
      check_main($sformatf("sweep_%04b", 4'(c)), exp_o[c], exp_yes[c], pass_exp);
    end
    check("sweep_total", 32'(pass_cnt), 32'(SWEEP_PASS));

    // Hold with en=0 while I changes.
    en = 1'b0; I = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      check_main($sformatf("hold%0d", k), 3'b100, 3'd4, 8'(SWEEP_PASS));
    end

    // Saturation on the 2-bit counter instance.
    en_s = 1'b1; i_s = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("sat%0d", k), 32'(pass_s), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    check("sat.O", 32'(o_s), 32'(3'b100));
    en_s = 1'b0;

    // Tie codes with and without chair vote.
    en = 1'b1; I = 4'b0011;
    step();
`ifdef VOTER_IF_TIEBREAK_EN
    check_main("tie_0011", 3'b100, 3'd2, 8'(SWEEP_PASS + 1));
`else
    check_main("tie_0011", 3'b010, 3'd2, 8'(SWEEP_PASS));
`endif
    I = 4'b0110;
    step();
`ifdef VOTER_IF_TIEBREAK_EN
    check_main("tie_0110", 3'b001, 3'd2, 8'(SWEEP_PASS + 1));
`else
    check_main("tie_0110", 3'b010, 3'd2, 8'(SWEEP_PASS));
`endif

    // Mid-operation reset while a pass vote is presented.
    rst_n = 1'b0; I = 4'b1110;
    step();
    check_main("midrst", 3'b000, 3'd0, 8'd0);
    check("midrst.sat_pass", 32'(pass_s), 32'd0);
    rst_n = 1'b1; en = 1'b0;
    step();
    check_main("midrst_hold", 3'b000, 3'd0, 8'd0);
    en = 1'b1;
    step();
    check_main("midrst_eval", 3'b100, 3'd3, 8'd1);

    // Back-to-back: fail right after pass, no memory.
    I = 4'b1000;
    step();
    check_main("b2b_fail", 3'b001, 3'd1, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
